ram2axi: RTL and testbench
==========================

RAM2AXI -- requirements
Module: ram2axi

Interface
REQ-001 SHALL have parameter ID_W_WIDTH, default 4, the AWID width.
REQ-002 SHALL have parameter ID_R_WIDTH, default 4, the ARID width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 4, the AXI and local RAM word-address width.
REQ-004 SHALL have parameter AXI_DATA_WIDTH, default 32, the data width; BYTE_WIDTH, default 8; BATCH_WIDTH = AXI_DATA_WIDTH/BYTE_WIDTH.
REQ-005 SHALL have ports:
- clk_i  in  1  sole clock; all logic on the rising edge.
- rst_n_i  in  1  reset; synchronous, active-low.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  command accepted when high together with cmd_valid_i.
- cmd_write_i  in  1  1 = RAM to AXI write; 0 = AXI read to RAM.
- cmd_axi_addr_i  in  ADDR_WIDTH  AXI start address.
- cmd_ram_addr_i  in  ADDR_WIDTH  local RAM start address.
- cmd_len_i  in  8  beats minus 1.
- cmd_id_i  in  ID_W_WIDTH  transaction ID; truncated or zero-extended to ID_R_WIDTH for reads.
- done_o  out  1  one-cycle completion pulse.
- resp_o  out  2  worst BRESP/RRESP of the finished command; valid with done_o.
- ram_addr_o  out  ADDR_WIDTH  local RAM address.
- ram_wdata_o  out  AXI_DATA_WIDTH  local RAM write data.
- ram_we_o  out  1  local RAM write enable.
- ram_byte_en_o  out  BATCH_WIDTH  local RAM byte enables.
- ram_rdata_i  in  AXI_DATA_WIDTH  local RAM read data; one-cycle read latency.
- out_mosi_o  out  axi_mosi_t  AXI manager outputs.
- out_miso_i  in  axi_miso_t  AXI subordinate responses.

Function
REQ-006 SHALL implement one FSM with states IDLE, AW, W_FETCH, W_DATA, B, AR, R, DONE; one command in flight.
REQ-007 SHALL assert cmd_ready_o only in IDLE and register all cmd_* fields on acceptance; a write command goes to AW, a read command goes to AR.
REQ-008 In AW/AR, SHALL drive the address channel as follows, holding every field stable until the READY handshake completes:
- AWVALID/ARVALID = 1.
- ADDR = registered AXI address; LEN = cmd_len.
- SIZE = log2(BATCH_WIDTH); BURST = 2'b01 (INCR).
- ID = cmd_id.
REQ-009 After the AW handshake the FSM SHALL go to W_FETCH.
REQ-010 W_FETCH SHALL drive ram_addr_o = current RAM address with ram_we_o=0, then go to W_DATA the next cycle.
REQ-011 In W_DATA, SHALL drive WVALID=1, WDATA = ram_rdata_i captured at entry, WSTRB all ones, and WLAST=1 only on the last beat.
REQ-012 In W_DATA, SHALL hold WDATA/WLAST stable while WREADY=0.
REQ-013 On a W handshake, SHALL increment the RAM address by 1 (wrapping modulo 2**ADDR_WIDTH) and decrement the beat counter; go to W_FETCH, or to B after the last beat.
REQ-014 In B, SHALL assert BREADY=1; on BVALID, capture BRESP and go to DONE.
REQ-015 After the AR handshake the FSM SHALL go to R.
REQ-016 In R, SHALL assert RREADY=1; each RVALID beat SHALL produce, in the same cycle:
- ram_we_o=1, ram_byte_en_o all ones;
- ram_wdata_o = RDATA, ram_addr_o = current RAM address;
- RAM address incremented with wrap.
REQ-017 In R, SHALL go to DONE on RLAST or when the beat counter is exhausted, whichever comes first.
REQ-018 SHALL accumulate resp_o as the numeric maximum of all RRESP values of the burst.
REQ-019 DONE SHALL pulse done_o for exactly one cycle and return to IDLE; a new command is accepted no earlier than the following cycle.
REQ-020 SHALL NOT split bursts at 4 KB boundaries; respecting them is the command issuer's obligation.
REQ-021 Outputs not specified for a state SHALL be 0; WVALID, ARVALID and AWVALID SHALL never deassert before their handshake completes.

Reset
REQ-022 On rst_n_i=0 at a clock edge, the block SHALL:
- return the FSM to IDLE;
- clear every VALID/READY output, ram_we_o, done_o, resp_o, counters and registered fields;
- drive cmd_ready_o=1 from the first cycle after reset.
REQ-023 A reset mid-burst SHALL abandon the burst with no further AXI or RAM activity.

Configuration
REQ-024 With macro RAM2AXI_PMU_EN defined, the block SHALL add two 32-bit saturating outputs, both cleared by reset:
- pmu_beats_o: count of completed W and R handshakes.
- pmu_stall_o: count of cycles any VALID is high while its READY is low.
REQ-025 Without RAM2AXI_PMU_EN, the PMU ports and logic SHALL be absent and behaviour is otherwise identical.

Verification
REQ-026 Write, len=3, RAM[0..3]=A0..A3, WREADY always 1 -> AWLEN=3, four W beats A0..A3, WLAST on the 4th, BRESP=0 -> done_o with resp_o=0.
REQ-027 Read, len=1, ram_addr=14 (ADDR_WIDTH 4), RDATA=5,6 -> RAM[14]=5, RAM[15]=6, RAM address wraps to 0, done_o.
REQ-028 Write with WREADY low 3 cycles on beat 2 -> WDATA stable, pmu_stall_o += 3 when enabled.
REQ-029 Read with RRESP 0 then 2 -> resp_o=2.
REQ-030 Reset asserted during beat 1 of a len=7 write -> next cycle all VALIDs 0, cmd_ready_o=1, no BREADY.

Source files
------------

// File: rtl/ram2axi.sv
// ram2axi: moves bursts between a local single-port RAM and an AXI manager port.
// Optional PMU counters are built when RAM2AXI_PMU_EN is defined.
package ram2axi_pkg;

  localparam int AXI_ID_W   = 4;
  localparam int AXI_ADDR_W = 4;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;

  typedef logic [AXI_ID_W-1:0]   axi_id_t;
  typedef logic [AXI_ADDR_W-1:0] axi_addr_t;
  typedef logic [AXI_DATA_W-1:0] axi_data_t;
  typedef logic [AXI_STRB_W-1:0] axi_strb_t;

  typedef struct packed {
    logic      awvalid;
    axi_id_t   awid;
    axi_addr_t awaddr;
    logic [7:0] awlen;
    logic [2:0] awsize;
    logic [1:0] awburst;
    logic      wvalid;
    axi_data_t wdata;
    axi_strb_t wstrb;
    logic      wlast;
    logic      bready;
    logic      arvalid;
    axi_id_t   arid;
    axi_addr_t araddr;
    logic [7:0] arlen;
    logic [2:0] arsize;
    logic [1:0] arburst;
    logic      rready;
  } axi_mosi_t;

  typedef struct packed {
    logic      awready;
    logic      wready;
    logic      bvalid;
    axi_id_t   bid;
    logic [1:0] bresp;
    logic      arready;
    logic      rvalid;
    axi_id_t   rid;
    axi_data_t rdata;
    logic [1:0] rresp;
    logic      rlast;
  } axi_miso_t;

endpackage

module ram2axi
  import ram2axi_pkg::*;
#(
  parameter int ID_W_WIDTH     = 4,
  parameter int ID_R_WIDTH     = 4,
  parameter int ADDR_WIDTH     = 4,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int BYTE_WIDTH     = 8,
  localparam int BATCH_WIDTH   = AXI_DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_write_i,
  input  logic [ADDR_WIDTH-1:0]     cmd_axi_addr_i,
  input  logic [ADDR_WIDTH-1:0]     cmd_ram_addr_i,
  input  logic [7:0]                cmd_len_i,
  input  logic [ID_W_WIDTH-1:0]     cmd_id_i,
  output logic                      done_o,
  output logic [1:0]                resp_o,
  output logic [ADDR_WIDTH-1:0]     ram_addr_o,
  output logic [AXI_DATA_WIDTH-1:0] ram_wdata_o,
  output logic                      ram_we_o,
  output logic [BATCH_WIDTH-1:0]    ram_byte_en_o,
  input  logic [AXI_DATA_WIDTH-1:0] ram_rdata_i,
  output axi_mosi_t                 out_mosi_o,
  input  axi_miso_t                 out_miso_i
`ifdef RAM2AXI_PMU_EN
  ,
  output logic [31:0]               pmu_beats_o,
  output logic [31:0]               pmu_stall_o
`endif
);

  localparam logic [2:0] SIZE = 3'($clog2(BATCH_WIDTH));

  typedef enum logic [2:0] {
    IDLE, AW, W_FETCH, W_DATA, B, AR, R, DONE
  } state_t;

  state_t                    state;
  logic [ADDR_WIDTH-1:0]     aaddr_q;
  logic [ADDR_WIDTH-1:0]     raddr_q;
  logic [7:0]                len_q;
  logic [7:0]                cnt_q;
  logic [ID_W_WIDTH-1:0]     id_q;
  logic [1:0]                resp_q;
  logic                      wfirst_q;
  logic [AXI_DATA_WIDTH-1:0] wdata_q;

  logic [AXI_DATA_WIDTH-1:0] rdata;
  logic [AXI_DATA_WIDTH-1:0] wdata;
  logic [ID_R_WIDTH-1:0]     id_r;
  logic                      unused_ok;

  assign rdata = AXI_DATA_WIDTH'(out_miso_i.rdata);
  assign id_r  = ID_R_WIDTH'(id_q);
  assign unused_ok = ^{out_miso_i.bid, out_miso_i.rid};

  // RAM data arrives the cycle after W_FETCH; hold it for stalled beats
  assign wdata = wfirst_q ? ram_rdata_i : wdata_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      aaddr_q  <= '0;
      raddr_q  <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      id_q     <= '0;
      resp_q   <= '0;
      wfirst_q <= 1'b0;
      wdata_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            aaddr_q <= cmd_axi_addr_i;
            raddr_q <= cmd_ram_addr_i;
            len_q   <= cmd_len_i;
            cnt_q   <= cmd_len_i;
            id_q    <= cmd_id_i;
            resp_q  <= '0;
            state   <= cmd_write_i ? AW : AR;
          end
        end
        AW: begin
          if (out_miso_i.awready) state <= W_FETCH;
        end
        W_FETCH: begin
          wfirst_q <= 1'b1;
          state    <= W_DATA;
        end
        W_DATA: begin
          wfirst_q <= 1'b0;
          if (wfirst_q) wdata_q <= ram_rdata_i;
          if (out_miso_i.wready) begin
            raddr_q <= raddr_q + 1'b1;
            if (cnt_q == 8'd0) begin
              state <= B;
            end else begin
              cnt_q <= cnt_q - 8'd1;
              state <= W_FETCH;
            end
          end
        end
        B: begin
          if (out_miso_i.bvalid) begin
            resp_q <= out_miso_i.bresp;
            state  <= DONE;
          end
        end
        AR: begin
          if (out_miso_i.arready) state <= R;
        end
        R: begin
          if (out_miso_i.rvalid) begin
            raddr_q <= raddr_q + 1'b1;
            if (out_miso_i.rresp > resp_q)
              resp_q <= out_miso_i.rresp;
            if (out_miso_i.rlast || cnt_q == 8'd0)
              state <= DONE;
            else
              cnt_q <= cnt_q - 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_ready_o = (state == IDLE);
  assign done_o      = (state == DONE);
  assign resp_o      = done_o ? resp_q : 2'b00;

  always_comb begin
    out_mosi_o    = '0;
    ram_addr_o    = '0;
    ram_wdata_o   = '0;
    ram_we_o      = 1'b0;
    ram_byte_en_o = '0;
    unique case (state)
      AW: begin
        out_mosi_o.awvalid = 1'b1;
        out_mosi_o.awid    = axi_id_t'(id_q);
        out_mosi_o.awaddr  = axi_addr_t'(aaddr_q);
        out_mosi_o.awlen   = len_q;
        out_mosi_o.awsize  = SIZE;
        out_mosi_o.awburst = 2'b01;
      end
      W_FETCH: begin
        ram_addr_o = raddr_q;
      end
      W_DATA: begin
        out_mosi_o.wvalid = 1'b1;
        out_mosi_o.wdata  = axi_data_t'(wdata);
        out_mosi_o.wstrb  = axi_strb_t'({BATCH_WIDTH{1'b1}});
        out_mosi_o.wlast  = (cnt_q == 8'd0);
      end
      B: begin
        out_mosi_o.bready = 1'b1;
      end
      AR: begin
        out_mosi_o.arvalid = 1'b1;
        out_mosi_o.arid    = axi_id_t'(id_r);
        out_mosi_o.araddr  = axi_addr_t'(aaddr_q);
        out_mosi_o.arlen   = len_q;
        out_mosi_o.arsize  = SIZE;
        out_mosi_o.arburst = 2'b01;
      end
      R: begin
        out_mosi_o.rready = 1'b1;
        if (out_miso_i.rvalid) begin
          ram_we_o      = 1'b1;
          ram_byte_en_o = '1;
          ram_wdata_o   = rdata;
          ram_addr_o    = raddr_q;
        end
      end
      default: ;
    endcase
  end

`ifdef RAM2AXI_PMU_EN
  logic beat;
  logic stall;

  assign beat =
    (out_mosi_o.wvalid & out_miso_i.wready) |
    (out_mosi_o.rready & out_miso_i.rvalid);

  assign stall =
    (out_mosi_o.awvalid & ~out_miso_i.awready) |
    (out_mosi_o.wvalid  & ~out_miso_i.wready)  |
    (out_mosi_o.arvalid & ~out_miso_i.arready) |
    (out_miso_i.bvalid  & ~out_mosi_o.bready)  |
    (out_miso_i.rvalid  & ~out_mosi_o.rready);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      pmu_beats_o <= '0;
      pmu_stall_o <= '0;
    end else begin
      if (beat && pmu_beats_o != '1)
        pmu_beats_o <= pmu_beats_o + 32'd1;
      if (stall && pmu_stall_o != '1)
        pmu_stall_o <= pmu_stall_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ram2axi.sv
// Bench for ram2axi: directed plus random bursts against a word-level RAM
// and AXI subordinate model held in the bench.
module tb_ram2axi;
  import ram2axi_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [3:0]  cmd_axi_addr = '0;
  logic [3:0]  cmd_ram_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic [3:0]  cmd_id = '0;
  logic        done;
  logic [1:0]  resp;
  logic [3:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic [3:0]  ram_byte_en;
  logic [31:0] ram_rdata = '0;
  axi_mosi_t   mosi;
  axi_miso_t   miso = '0;
`ifdef RAM2AXI_PMU_EN
  logic [31:0] pmu_beats;
  logic [31:0] pmu_stall;
  logic [31:0] snap_beats;
  logic [31:0] snap_stall;
`endif

  always #5 clk = ~clk;

  ram2axi dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .cmd_valid_i    (cmd_valid),
    .cmd_ready_o    (cmd_ready),
    .cmd_write_i    (cmd_write),
    .cmd_axi_addr_i (cmd_axi_addr),
    .cmd_ram_addr_i (cmd_ram_addr),
    .cmd_len_i      (cmd_len),
    .cmd_id_i       (cmd_id),
    .done_o         (done),
    .resp_o         (resp),
    .ram_addr_o     (ram_addr),
    .ram_wdata_o    (ram_wdata),
    .ram_we_o       (ram_we),
    .ram_byte_en_o  (ram_byte_en),
    .ram_rdata_i    (ram_rdata),
    .out_mosi_o     (mosi),
    .out_miso_i     (miso)
`ifdef RAM2AXI_PMU_EN
    ,
    .pmu_beats_o    (pmu_beats),
    .pmu_stall_o    (pmu_stall)
`endif
  );

  logic [31:0] ram_mem [16];
  logic [31:0] ref_ram [16];
  logic [31:0] rd_q [$];
  logic [1:0]  rr_q [$];

  // Synchronous RAM with one-cycle read latency
  always @(posedge clk) begin
    if (ram_we)
      for (int b = 0; b < 4; b++)
        if (ram_byte_en[b])
          ram_mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    ram_rdata <= ram_mem[ram_addr];
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input bit wr, input logic [3:0] aa,
                       input logic [3:0] ra, input logic [7:0] len,
                       input logic [3:0] id);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_axi_addr = aa;
    cmd_ram_addr = ra;
    cmd_len = len;
    cmd_id = id;
    #1;
    chk("cmd_ready", cmd_ready, 1);
    @(posedge clk);
  endtask

  task automatic addr_phase(input bit wr, input logic [3:0] aa,
                            input logic [7:0] len, input logic [3:0] id,
                            input int dly);
    int d = dly;
    bit hs = 0;
    for (int c = 0; c < 50 && !hs; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (wr) miso.awready = (d == 0);
      else    miso.arready = (d == 0);
      #1;
      if (wr) begin
        chk("awvalid", mosi.awvalid, 1);
        chk("awaddr", mosi.awaddr, aa);
        chk("awlen", mosi.awlen, len);
        chk("awsize", mosi.awsize, 2);
        chk("awburst", mosi.awburst, 1);
        chk("awid", mosi.awid, id);
      end else begin
        chk("arvalid", mosi.arvalid, 1);
        chk("araddr", mosi.araddr, aa);
        chk("arlen", mosi.arlen, len);
        chk("arsize", mosi.arsize, 2);
        chk("arburst", mosi.arburst, 1);
        chk("arid", mosi.arid, id);
      end
      if (d == 0) hs = 1;
      else d--;
    end
    if (!hs) chk("addr_timeout", 0, 1);
  endtask

  task automatic w_phase(input logic [3:0] ra, input logic [7:0] len,
                         input int stall_beat, input int stall_n,
                         input bit rnd);
    int beat = 0;
    int left = stall_n;
    bit wr;
    logic [3:0] idx;
    for (int c = 0; c < 2000 && beat <= int'(len); c++) begin
      @(negedge clk);
      miso.awready = 1'b0;
      if (beat == stall_beat && left > 0) wr = 0;
      else wr = rnd ? ($urandom_range(3) != 0) : 1'b1;
      miso.wready = wr;
      #1;
      idx = ra + 4'(beat);
      if (mosi.wvalid) begin
        chk("wdata", mosi.wdata, ref_ram[idx]);
        chk("wlast", mosi.wlast, beat == int'(len));
        chk("wstrb", mosi.wstrb, 4'hf);
        if (wr) beat++;
        else if (beat == stall_beat && left > 0) left--;
      end else begin
        chk("fetch_addr", {ram_we, ram_addr}, {1'b0, idx});
      end
    end
    if (beat <= int'(len)) chk("w_timeout", 0, 1);
  endtask

  task automatic done_check(input logic [1:0] exp_resp);
    @(negedge clk);
    miso = '0;
    #1;
    chk("done", done, 1);
    chk("resp", resp, exp_resp);
    chk("ready_in_done", cmd_ready, 0);
    @(negedge clk);
    #1;
    chk("done_pulse", done, 0);
    chk("ready_after", cmd_ready, 1);
  endtask

  task automatic b_phase(input logic [1:0] br, input int dly);
    int d = dly;
    bit hs = 0;
    for (int c = 0; c < 50 && !hs; c++) begin
      @(negedge clk);
      miso.wready = 1'b0;
      miso.bvalid = (d == 0);
      miso.bresp = br;
      #1;
      chk("bready", mosi.bready, 1);
      if (d == 0) hs = 1;
      else d--;
    end
    if (!hs) chk("b_timeout", 0, 1);
    done_check(br);
  endtask

  task automatic r_phase(input logic [3:0] ra, input bit use_last,
                         input bit rnd);
    int b = 0;
    int n = rd_q.size();
    logic [3:0] idx;
    logic [1:0] worst = 2'b00;
    for (int c = 0; c < 2000 && b < n; c++) begin
      @(negedge clk);
      miso.arready = 1'b0;
      if (rnd && $urandom_range(3) == 0) begin
        miso.rvalid = 1'b0;
        miso.rlast = 1'b0;
        #1;
        chk("rready_gap", mosi.rready, 1);
        chk("we_gap", ram_we, 0);
      end else begin
        idx = ra + 4'(b);
        miso.rvalid = 1'b1;
        miso.rdata = rd_q[b];
        miso.rresp = rr_q[b];
        miso.rlast = use_last && (b == n - 1);
        #1;
        chk("rready", mosi.rready, 1);
        chk("ram_we", ram_we, 1);
        chk("ram_be", ram_byte_en, 4'hf);
        chk("ram_addr", ram_addr, idx);
        chk("ram_wdata", ram_wdata, rd_q[b]);
        ref_ram[idx] = rd_q[b];
        if (rr_q[b] > worst) worst = rr_q[b];
        b++;
      end
    end
    if (b < n) chk("r_timeout", 0, 1);
    done_check(worst);
  endtask

  task automatic do_write(input logic [3:0] aa, input logic [3:0] ra,
                          input logic [7:0] len, input logic [3:0] id,
                          input int sb, input int sn, input bit rnd,
                          input logic [1:0] br);
    issue(1'b1, aa, ra, len, id);
    addr_phase(1'b1, aa, len, id, rnd ? $urandom_range(2) : 0);
    w_phase(ra, len, sb, sn, rnd);
    b_phase(br, rnd ? $urandom_range(2) : 0);
  endtask

  task automatic do_read(input logic [3:0] aa, input logic [3:0] ra,
                         input logic [7:0] len, input logic [3:0] id,
                         input bit use_last, input bit rnd);
    issue(1'b0, aa, ra, len, id);
    addr_phase(1'b0, aa, len, id, rnd ? $urandom_range(2) : 0);
    r_phase(ra, use_last, rnd);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      ram_mem[i] = $urandom;
      ref_ram[i] = ram_mem[i];
    end
    for (int i = 0; i < 4; i++) begin
      ram_mem[i] = 32'hA0 + i;
      ref_ram[i] = ram_mem[i];
    end

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_resp", resp, 0);
    chk("rst_mosi", mosi == '0, 1);
    chk("rst_we", ram_we, 0);
`ifdef RAM2AXI_PMU_EN
    chk("rst_pmu_beats", pmu_beats, 0);
    chk("rst_pmu_stall", pmu_stall, 0);
`endif
    rst_n = 1'b1;

    // Write len=3 from RAM[0..3], WREADY always high
    do_write(4'h5, 4'h0, 8'd3, 4'h9, -1, 0, 1'b0, 2'b00);

    // Read len=1 into RAM[14], RAM[15] with address wrap
    rd_q = '{32'd5, 32'd6};
    rr_q = '{2'd0, 2'd0};
    do_read(4'h2, 4'he, 8'd1, 4'h3, 1'b1, 1'b0);
    chk("ram14", ram_mem[14], 5);
    chk("ram15", ram_mem[15], 6);

    // Write with WREADY low for 3 cycles on the second beat
`ifdef RAM2AXI_PMU_EN
    snap_beats = pmu_beats;
    snap_stall = pmu_stall;
`endif
    do_write(4'h7, 4'h4, 8'd3, 4'h1, 1, 3, 1'b0, 2'b00);
`ifdef RAM2AXI_PMU_EN
    chk("pmu_beats", pmu_beats - snap_beats, 4);
    chk("pmu_stall", pmu_stall - snap_stall, 3);
`endif

    // Worst RRESP wins
    rd_q = '{$urandom, $urandom};
    rr_q = '{2'd0, 2'd2};
    do_read(4'h0, 4'h8, 8'd1, 4'h6, 1'b1, 1'b0);

    // Early RLAST ends a len=5 read after 3 beats
    rd_q = '{$urandom, $urandom, $urandom};
    rr_q = '{2'd1, 2'd0, 2'd0};
    do_read(4'h3, 4'ha, 8'd5, 4'h2, 1'b1, 1'b0);

    // Counter exhaustion ends a read without RLAST
    rd_q = '{$urandom, $urandom, $urandom};
    rr_q = '{2'd0, 2'd3, 2'd1};
    do_read(4'h9, 4'h1, 8'd2, 4'hc, 1'b0, 1'b0);

    // Error BRESP reported
    do_write(4'hf, 4'hd, 8'd0, 4'h4, -1, 0, 1'b0, 2'b10);

    // Random traffic
    for (int t = 0; t < 16; t++) begin
      logic [3:0] aa;
      logic [3:0] ra;
      logic [7:0] len;
      logic [3:0] id;
      int nb;
      bit ul;
      aa = 4'($urandom);
      ra = 4'($urandom);
      len = 8'($urandom_range(7));
      id = 4'($urandom);
      if ($urandom_range(1) == 1) begin
        do_write(aa, ra, len, id, -1, 0, 1'b1, 2'($urandom));
      end else begin
        nb = $urandom_range(int'(len) + 1, 1);
        ul = (nb < int'(len) + 1) ? 1'b1 : 1'($urandom);
        rd_q = {};
        rr_q = {};
        for (int i = 0; i < nb; i++) begin
          rd_q.push_back($urandom);
          rr_q.push_back(2'($urandom));
        end
        do_read(aa, ra, len, id, ul, 1'b1);
      end
    end

    // Reset during the first beat of a len=7 write
    issue(1'b1, 4'h1, 4'h2, 8'd7, 4'h5);
    addr_phase(1'b1, 4'h1, 8'd7, 4'h5, 0);
    @(negedge clk);
    miso.awready = 1'b0;
    miso.wready = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_wvalid", mosi.wvalid, 1);
    rst_n = 1'b0;
    @(negedge clk);
    miso.wready = 1'b1;
    #1;
    chk("abort_mosi", mosi == '0, 1);
    chk("abort_bready", mosi.bready, 0);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_we", ram_we, 0);
    chk("abort_done", done, 0);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("quiet_mosi", mosi == '0, 1);
      chk("quiet_we", ram_we, 0);
    end
    miso = '0;
`ifdef RAM2AXI_PMU_EN
    chk("abort_pmu", pmu_beats, 0);
`endif

    // Recovery after the abandoned burst
    do_write(4'h4, 4'hc, 8'd1, 4'ha, -1, 0, 1'b0, 2'b01);

    for (int i = 0; i < 16; i++)
      chk($sformatf("ram_final[%0d]", i), ram_mem[i], ref_ram[i]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
